alu_sequencer: RTL and testbench

- Initiator side of the ALU operand/opcode interface.
- Accepts 16-bit register-form instructions through a valid/ready handshake and reads operands from an internal 16x32 register file.
- Drives OPCODE/A/B to an external combinational ALU, then captures Result and NZVC/Error.
- Writes back the result and flags; halts permanently on an ALU error until reset.

---
 rtl/alu_seq_pkg.sv | 48 ++++
 rtl/regfile_16x32.sv | 62 ++++++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, instruction
// field positions, opcode encodings and field-extraction helpers.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b1101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;

    function automatic logic [3:0] field_opc(input logic [15:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [3:0] field_rd(input logic [15:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [3:0] field_rs1(input logic [15:0] ir);
        return ir[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [3:0] field_rs2(input logic [15:0] ir);
        return ir[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/regfile_16x32.sv
// 16x32 register file: two operand read ports, one debug read port and a
// single write port shared between writeback and preload. R0 reads as zero.
module regfile_16x32 #(
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic [AW-1:0] dbg_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [31:0]   wb_data,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [31:0]   rs1_data,
    output logic [31:0]   rs2_data,
    output logic [31:0]   dbg_data
);

    logic [31:0]   regs_r [NREGS];
    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic [31:0]   wdata_s;

    // Write-port arbiter; writeback and preload are never active together
    // but writeback is given priority so the selection is fully defined.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = {AW{1'b0}};
        wdata_s = 32'd0;
        if (wb_en) begin
            we_s    = 1'b1;
            waddr_s = wb_addr;
            wdata_s = wb_data;
        end else if (load_en) begin
            we_s    = 1'b1;
            waddr_s = load_addr;
            wdata_s = load_data;
        end else begin
            we_s    = 1'b0;
        end
    end

    // Register storage; writes aimed at R0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (we_s && (waddr_s != {AW{1'b0}})) begin
            regs_r[waddr_s] <= wdata_s;
        end
    end

    assign rs1_data = (rs1_addr == {AW{1'b0}}) ? 32'd0 : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == {AW{1'b0}}) ? 32'd0 : regs_r[rs2_addr];
    assign dbg_data = (dbg_addr == {AW{1'b0}}) ? 32'd0 : regs_r[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external combinational ALU: fetch operands,
// capture the ALU response, write back, and halt on an ALU error until reset.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    input  logic             load_valid,
    input  logic [3:0]       load_addr,
    input  logic [31:0]      load_data,
    input  logic [3:0]       dbg_addr,
    output logic [31:0]      dbg_data,
    output logic [3:0]       alu_opcode,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_c,
    input  logic             alu_error,
    output logic [3:0]       flags,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [15:0]        ir_r;
    logic [31:0]        res_r;
    logic [3:0]         nzvc_r;
    logic               aerr_r;
    logic [3:0]         flags_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        rs1_data_s;
    logic [31:0]        rs2_data_s;
    logic               wb_go_s;
    logic               load_go_s;

    assign wb_go_s   = (state_r == WB) && !aerr_r && !reset;
    assign load_go_s = (state_r == IDLE) && load_valid && !reset;

    regfile_16x32 #(
        .NREGS (NREGS),
        .AW    (4)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rs1_addr  (field_rs1(ir_r)),
        .rs2_addr  (field_rs2(ir_r)),
        .dbg_addr  (dbg_addr),
        .wb_en     (wb_go_s),
        .wb_addr   (field_rd(ir_r)),
        .wb_data   (res_r),
        .load_en   (load_go_s),
        .load_addr (load_addr),
        .load_data (load_data),
        .rs1_data  (rs1_data_s),
        .rs2_data  (rs2_data_s),
        .dbg_data  (dbg_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; HALT is only left through reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (instr_valid) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = WB;
            WB: begin
                if (aerr_r) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HALT:    state_nxt_s = HALT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State-decoded outputs; forced quiet while reset is asserted so an
    // interrupted instruction never shows done or drives the ALU.
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        alu_opcode  = 4'd0;
        alu_a       = 32'd0;
        alu_b       = 32'd0;
        if (reset) begin
            instr_ready = 1'b0;
        end else begin
            case (state_r)
                IDLE: instr_ready = 1'b1;
                EXEC: begin
                    alu_opcode = field_opc(ir_r);
                    alu_a      = rs1_data_s;
                    alu_b      = rs2_data_s;
                end
                WB: begin
                    if (aerr_r) begin
                        done = 1'b0;
                    end else begin
                        done = 1'b1;
                    end
                end
                HALT:    error = 1'b1;
                default: instr_ready = 1'b0;
            endcase
        end
    end

    // Instruction latch, ALU response capture and retirement bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_r    <= 16'd0;
            res_r   <= 32'd0;
            nzvc_r  <= 4'd0;
            aerr_r  <= 1'b0;
            flags_r <= 4'd0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if ((state_r == IDLE) && instr_valid) begin
                ir_r <= instr;
            end
            if (state_r == EXEC) begin
                res_r  <= alu_result;
                nzvc_r <= {alu_n, alu_z, alu_v, alu_c};
                aerr_r <= alu_error;
            end
            if (wb_go_s) begin
                flags_r <= nzvc_r;
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign flags       = flags_r;
    assign instr_count = cnt_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions push hand-computed
// retirements; a monitor pops and checks them whenever done is seen.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        load_valid;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_n, alu_z, alu_v, alu_c, alu_error;
    logic [3:0]  flags;
    logic        done;
    logic        error;
    logic [15:0] instr_count;

    typedef struct {
        int          acc;
        logic [31:0] val;
        logic [3:0]  flg;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   exp_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .alu_error   (alu_error),
        .flags       (flags),
        .done        (done),
        .error       (error),
        .instr_count (instr_count)
    );

    // External combinational ALU model; C on SUB is the unsigned borrow.
    logic [32:0] sum;
    always_comb begin
        alu_result = 32'd0;
        alu_v      = 1'b0;
        alu_c      = 1'b0;
        alu_error  = 1'b0;
        sum        = 33'd0;
        case (alu_opcode)
            ADD: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[31:0];
                alu_c      = sum[32];
                alu_v      = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            SUB: begin
                alu_result = alu_a - alu_b;
                alu_c      = alu_a < alu_b;
                alu_v      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            SLL:  alu_result = alu_a << alu_b[4:0];
            SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            SLTU: alu_result = {31'd0, alu_a < alu_b};
            XOR:  alu_result = alu_a ^ alu_b;
            SRL:  alu_result = alu_a >> alu_b[4:0];
            SRA:  alu_result = $signed(alu_a) >>> alu_b[4:0];
            OR:   alu_result = alu_a | alu_b;
            AND:  alu_result = alu_a & alu_b;
            default: alu_error = 1'b1;
        endcase
    end
    assign alu_n = alu_result[31];
    assign alu_z = (alu_result == 32'd0);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = v;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Offer one instruction (optionally with a same-edge preload) and queue
    // its expected retirement.
    task automatic issue(input logic [15:0] ins, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ev, input logic [3:0] ef,
                         input bit ld, input logic [3:0] la, input logic [31:0] lv);
        exp_t e;
        @(negedge clk);
        chk("ready_idle", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        dbg_addr    = ins[11:8];
        load_valid  = ld;
        load_addr   = la;
        load_data   = lv;
        exp_count++;
        e.acc = cyc;
        e.val = ev;
        e.flg = ef;
        e.cnt = 16'(exp_count);
        sb_q.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0;
        load_valid  = 1'b0;
        chk("ready_exec", 32'(instr_ready), 32'd0);
        chk("alu_opcode", 32'(alu_opcode), 32'(ins[15:12]));
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every done must match the oldest queued retirement.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1 expected no retirement (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.acc + 2));
                    @(negedge clk);
                    chk("done_width", 32'(done), 32'd0);
                    chk("flags", 32'(flags), 32'(e.flg));
                    chk("instr_count", 32'(instr_count), 32'(e.cnt));
                    chk("rd_value", dbg_data, e.val);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'd0;
        load_valid  = 1'b0;
        load_addr   = 4'd0;
        load_data   = 32'd0;
        dbg_addr    = 4'd5;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_alu_op", 32'(alu_opcode), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_reg", dbg_data, 32'd0);

        load(4'd1, 32'd5);
        load(4'd2, 32'd3);
        issue(16'h0312, 32'd5, 32'd3, 32'd8, 4'b0000, 1'b0, 4'd0, 32'd0);
        issue(16'h8421, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1001, 1'b0, 4'd0, 32'd0);
        load(4'd5, 32'h7FFF_FFFF);
        load(4'd6, 32'd1);
        issue(16'h0756, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1010, 1'b0, 4'd0, 32'd0);

        // Illegal opcode: halt, no retirement, loads ignored.
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'h9312;
        dbg_addr    = 4'd3;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("err_alu_op", 32'(alu_opcode), 32'd9);
        repeat (2) @(negedge clk);
        chk("halt_error", 32'(error), 32'd1);
        chk("halt_ready", 32'(instr_ready), 32'd0);
        chk("halt_r3", dbg_data, 32'd8);
        chk("halt_flags", 32'(flags), 32'b1010);
        chk("halt_count", 32'(instr_count), 32'd3);
        load_valid  = 1'b1;
        load_addr   = 4'd3;
        load_data   = 32'h55;
        instr_valid = 1'b1;
        instr       = 16'h0312;
        @(negedge clk);
        load_valid  = 1'b0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_load_ign", dbg_data, 32'd8);
        chk("halt_error2", 32'(error), 32'd1);
        chk("halt_ready2", 32'(instr_ready), 32'd0);
        chk("halt_alu_a", alu_a, 32'd0);
        reset = 1'b1;
        exp_count = 0;
        #1;
        chk("rst_err_low", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("unhalt_error", 32'(error), 32'd0);
        chk("unhalt_ready", 32'(instr_ready), 32'd1);
        chk("unhalt_count", 32'(instr_count), 32'd0);
        chk("unhalt_flags", 32'(flags), 32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk("reg_cleared", dbg_data, 32'd0);
        end

        // Same-edge preload and instruction; R0 write discarded.
        issue(16'h0011, 32'd10, 32'd10, 32'd0, 4'b0000, 1'b1, 4'd1, 32'd10);
        issue(16'h4211, 32'd10, 32'd10, 32'd0, 4'b0100, 1'b0, 4'd0, 32'd0);

        // Reset during EXEC aborts the instruction.
        load(4'd1, 32'd5);
        load(4'd2, 32'd3);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'h0312;
        dbg_addr    = 4'd3;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("abort_alu_a", alu_a, 32'd5);
        reset = 1'b1;
        exp_count = 0;
        #1;
        chk("abort_alu_quiet", alu_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_r3", dbg_data, 32'd0);
        chk("abort_count", 32'(instr_count), 32'd0);
        chk("abort_done", 32'(done), 32'd0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
